// File: rtl/mem_wb_pipe_pkg.sv
// rtl/mem_wb_pipe_pkg.sv - shared types for the MEM/WB stage
package mem_wb_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } stage_state_t;

  typedef struct packed {
    logic                  mreg;
    logic                  enrw;
    logic [REG_AW_DEF-1:0] wn;
    logic [DATA_W_DEF-1:0] read_data;
    logic [DATA_W_DEF-1:0] alu_result;
  } wb_entry_t;

  function automatic int entry_width(input int reg_aw, input int data_w);
    return 2 + reg_aw + 2 * data_w;
  endfunction

endpackage

// File: rtl/mem_wb_pipe_entry.sv
// rtl/mem_wb_pipe_entry.sv - one valid+payload register with load and clear
module pipe_entry_reg
  import mem_wb_pipe_pkg::*;
#(
  parameter int W = $bits(wb_entry_t)
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  // clear only drops the valid bit; payload of an invalid entry is don't-care
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      valid <= 1'b0;
      q     <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      q     <= d;
    end
  end

endmodule

// File: rtl/mem_wb_pipe.sv
// rtl/mem_wb_pipe.sv - MEM/WB stage with skid buffer, flush and write-back port
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int CNT_W    = 16,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mreg,
  input  logic              in_enrw,
  input  logic [REG_AW-1:0] in_wn,
  input  logic [DATA_W-1:0] in_read_data,
  input  logic [DATA_W-1:0] in_alu_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mreg,
  output logic              out_enrw,
  output logic [REG_AW-1:0] out_wn,
  output logic [DATA_W-1:0] out_read_data,
  output logic [DATA_W-1:0] out_alu_result,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_wn,
  output logic [DATA_W-1:0] wb_data,
  output logic              fwd_valid,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic              mreg;
    logic              enrw;
    logic [REG_AW-1:0] wn;
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
  } entry_t;

  localparam int EW = entry_width(REG_AW, DATA_W);

  stage_state_t state;
  entry_t       in_entry, main_d, main_q, skid_q;
  logic         main_v, skid_v;
  logic         in_fire, out_fire;
  logic         main_load, main_clear, skid_load, skid_clear;

  assign in_ready = (state != SKID);
  assign in_fire  = in_valid & in_ready & ~flush;
  assign out_fire = main_v & out_ready & ~flush;
  assign in_entry = {in_mreg, in_enrw, in_wn, in_read_data, in_alu_result};

  always_comb begin
    main_load  = 1'b0;
    main_clear = flush;
    skid_load  = 1'b0;
    skid_clear = flush;
    main_d     = in_entry;
    if (!flush) begin
      case (state)
        EMPTY: main_load = in_fire;
        FULL: begin
          main_load  = in_fire & out_fire;
          skid_load  = in_fire & ~out_fire;
          main_clear = ~in_fire & out_fire;
        end
        SKID: begin
          main_load  = out_fire & skid_v;
          skid_clear = out_fire;
          main_d     = skid_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) state <= FULL;
        FULL: begin
          if (in_fire && !out_fire)      state <= SKID;
          else if (!in_fire && out_fire) state <= EMPTY;
        end
        SKID:    if (out_fire) state <= FULL;
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_entry_reg #(.W(EW)) u_main (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .load  (main_load),
    .clear (main_clear),
    .d     (main_d),
    .valid (main_v),
    .q     (main_q)
  );

  pipe_entry_reg #(.W(EW)) u_skid (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .load  (skid_load),
    .clear (skid_clear),
    .d     (in_entry),
    .valid (skid_v),
    .q     (skid_q)
  );

  // saturates rather than wraps so long stalls stay visible
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stall_cnt <= '0;
    end else if (main_v && !out_ready && !flush && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign out_valid      = main_v;
  assign out_mreg       = main_q.mreg;
  assign out_enrw       = main_q.enrw;
  assign out_wn         = main_q.wn;
  assign out_read_data  = main_q.read_data;
  assign out_alu_result = main_q.alu_result;
  assign wb_wn          = main_q.wn;
  assign wb_data        = main_q.mreg ? main_q.read_data : main_q.alu_result;
  assign fwd_valid      = main_v & main_q.enrw;
  assign wb_we          = out_fire & main_q.enrw & ~(ZERO_REG && (main_q.wn == '0));

endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb/tb_mem_wb_pipe.sv - self-checking bench for mem_wb_pipe against a queue model
module tb_mem_wb_pipe;

  typedef struct packed {
    logic        mreg;
    logic        enrw;
    logic [3:0]  wn;
    logic [31:0] rd;
    logic [31:0] alu;
  } ent_t;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_mreg = 1'b0;
  logic        in_enrw = 1'b0;
  logic [3:0]  in_wn = '0;
  logic [31:0] in_read_data = '0;
  logic [31:0] in_alu_result = '0;
  logic        out_ready = 1'b0;

  logic        ir_a, ov_a, om_a, oe_a, we_a, fv_a;
  logic [3:0]  own_a, wwn_a;
  logic [31:0] ord_a, oal_a, wd_a;
  logic [15:0] stall_a;
  logic        ir_b, ov_b, om_b, oe_b, we_b, fv_b;
  logic [3:0]  own_b, wwn_b;
  logic [31:0] ord_b, oal_b, wd_b;
  logic [3:0]  stall_b;

  mem_wb_pipe dut_a (
    .Clk(Clk), .Rst_n(Rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
    .in_mreg(in_mreg), .in_enrw(in_enrw), .in_wn(in_wn), .in_read_data(in_read_data),
    .in_alu_result(in_alu_result), .out_valid(ov_a), .out_ready(out_ready),
    .out_mreg(om_a), .out_enrw(oe_a), .out_wn(own_a), .out_read_data(ord_a),
    .out_alu_result(oal_a), .wb_we(we_a), .wb_wn(wwn_a), .wb_data(wd_a),
    .fwd_valid(fv_a), .stall_cnt(stall_a)
  );

  mem_wb_pipe #(.CNT_W(4)) dut_b (
    .Clk(Clk), .Rst_n(Rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
    .in_mreg(in_mreg), .in_enrw(in_enrw), .in_wn(in_wn), .in_read_data(in_read_data),
    .in_alu_result(in_alu_result), .out_valid(ov_b), .out_ready(out_ready),
    .out_mreg(om_b), .out_enrw(oe_b), .out_wn(own_b), .out_read_data(ord_b),
    .out_alu_result(oal_b), .wb_we(we_b), .wb_wn(wwn_b), .wb_data(wd_b),
    .fwd_valid(fv_b), .stall_cnt(stall_b)
  );

  always #5 Clk = ~Clk;

  int   tests = 0;
  int   fails = 0;
  ent_t held[$];
  int   cnt  = 0;
  int   cnt4 = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_dut(input string nm, input logic ir, input logic ov,
                           input logic om, input logic oe, input logic [3:0] own,
                           input logic [31:0] ord, input logic [31:0] oal,
                           input logic we, input logic [3:0] wwn,
                           input logic [31:0] wd, input logic fv);
    chk({nm, ".in_ready"}, ir, held.size() < 2);
    chk({nm, ".out_valid"}, ov, held.size() > 0);
    if (held.size() > 0) begin
      ent_t h;
      h = held[0];
      chk({nm, ".out_mreg"}, om, h.mreg);
      chk({nm, ".out_enrw"}, oe, h.enrw);
      chk({nm, ".out_wn"}, own, h.wn);
      chk({nm, ".out_read_data"}, ord, h.rd);
      chk({nm, ".out_alu_result"}, oal, h.alu);
      chk({nm, ".wb_wn"}, wwn, h.wn);
      chk({nm, ".wb_data"}, wd, h.mreg ? h.rd : h.alu);
      chk({nm, ".fwd_valid"}, fv, h.enrw);
      chk({nm, ".wb_we"}, we, out_ready && !flush && h.enrw && (h.wn != 4'd0));
    end else begin
      chk({nm, ".wb_we_idle"}, we, 1'b0);
      chk({nm, ".fwd_valid_idle"}, fv, 1'b0);
    end
  endtask

  task automatic check_all();
    check_dut("a", ir_a, ov_a, om_a, oe_a, own_a, ord_a, oal_a, we_a, wwn_a, wd_a, fv_a);
    check_dut("b", ir_b, ov_b, om_b, oe_b, own_b, ord_b, oal_b, we_b, wwn_b, wd_b, fv_b);
    chk("stall_cnt", stall_a, cnt);
    chk("stall_cnt4", stall_b, cnt4);
  endtask

  // One clock: drive, check before the edge, then advance the queue model.
  task automatic cyc(input logic v, input logic ordy, input logic fl, input ent_t e);
    logic acc, stall;
    in_valid  = v;
    out_ready = ordy;
    flush     = fl;
    {in_mreg, in_enrw, in_wn, in_read_data, in_alu_result} = e;
    #3;
    check_all();
    acc   = v && (held.size() < 2);
    stall = (held.size() > 0) && !ordy && !fl;
    @(posedge Clk);
    if (fl) begin
      held.delete();
    end else begin
      if (ordy && held.size() > 0) void'(held.pop_front());
      if (acc) held.push_back(e);
    end
    if (stall) begin
      if (cnt < 65535) cnt++;
      if (cnt4 < 15) cnt4++;
    end
    #1;
  endtask

  function automatic ent_t rnd_ent();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[69:0];
  endfunction

  function automatic ent_t mk(input logic m, input logic en, input logic [3:0] wn,
                              input logic [31:0] rd, input logic [31:0] alu);
    return {m, en, wn, rd, alu};
  endfunction

  initial begin
    in_valid = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    check_all();
    chk("rst.out_wn", own_a, 4'd0);
    chk("rst.out_alu_result", oal_a, 32'd0);
    Rst_n = 1'b1;

    cyc(1'b1, 1'b1, 1'b0, mk(1'b0, 1'b1, 4'd5, $urandom, 32'h1234));
    cyc(1'b0, 1'b1, 1'b0, rnd_ent());

    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, rnd_ent());
    cyc(1'b0, 1'b1, 1'b0, rnd_ent());

    repeat (2) cyc(1'b1, 1'b1, 1'b0, rnd_ent());
    repeat (3) cyc(1'b1, 1'b0, 1'b0, rnd_ent());
    repeat (4) cyc(1'b1, 1'b1, 1'b0, rnd_ent());
    repeat (3) cyc(1'b0, 1'b1, 1'b0, rnd_ent());
    chk("stall_after_3", stall_a, 16'd3);

    repeat (2) cyc(1'b1, 1'b0, 1'b0, rnd_ent());
    cyc(1'b1, 1'b0, 1'b1, rnd_ent());
    cyc(1'b0, 1'b1, 1'b0, rnd_ent());

    cyc(1'b1, 1'b1, 1'b0, mk(1'b0, 1'b1, 4'd0, 32'hDEADBEEF, $urandom));
    cyc(1'b1, 1'b1, 1'b0, mk(1'b1, 1'b1, 4'd0, 32'hDEADBEEF, $urandom));
    cyc(1'b0, 1'b1, 1'b0, rnd_ent());

    for (int i = 0; i < 60; i++)
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 15) == 0), rnd_ent());

    cyc(1'b1, 1'b0, 1'b0, rnd_ent());
    repeat (20) cyc(1'b0, 1'b0, 1'b0, rnd_ent());
    chk("stall4_saturated", stall_b, 4'd15);

    repeat (2) cyc(1'b1, 1'b0, 1'b0, rnd_ent());
    Rst_n = 1'b0;
    held.delete();
    cnt  = 0;
    cnt4 = 0;
    #2;
    check_all();
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, rnd_ent());
    cyc(1'b0, 1'b1, 1'b0, rnd_ent());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
